// File: rtl/proc_pkg.sv
// Shared types and field positions for the processor control unit.
package proc_pkg;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        HALT = 3'd4
    } step_e;

    localparam int OPC_HI = 8;
    localparam int OPC_LO = 6;
    localparam int RX_HI  = 5;
    localparam int RX_LO  = 3;
    localparam int RY_HI  = 2;
    localparam int RY_LO  = 0;

endpackage

// File: rtl/proc_step_counter.sv
// Two-bit time-slot counter with synchronous clear and count enable.
module proc_step_counter (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] cnt
);

    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = 2'd0;
        else if (en)
            cnt_d = cnt_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/proc_control_fsm.sv
// Instruction sequencing control for the simple processor.
// Define PROC_CTRL_HALT_EN to make opcode 111 halt until reset.
module proc_control_fsm
    import proc_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int SEL_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [INSTR_W-1:0] din,
    output logic               ir_in,
    output logic [SEL_W-1:0]   rin_sel,
    output logic               rin_en,
    output logic [SEL_W-1:0]   rout_sel,
    output logic               rout_en,
    output logic               din_out,
    output logic               a_in,
    output logic               g_in,
    output logic               g_out,
    output logic               add_sub,
    output logic               done,
    output logic               halted
);

    step_e              step;
    logic [1:0]         cnt;
    logic               cnt_en;
    logic               cnt_clr;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [SEL_W-1:0]   rout_sel_q, rout_sel_d;
    logic [2:0]         opc;

    assign opc = ir_q[OPC_HI:OPC_LO];

`ifdef PROC_CTRL_HALT_EN
    logic halt_q, halt_d;
    assign step = halt_q ? HALT : step_e'({1'b0, cnt});
`else
    assign step = step_e'({1'b0, cnt});
`endif

    always_comb begin
        ir_in      = 1'b0;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        din_out    = 1'b0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        g_out      = 1'b0;
        add_sub    = 1'b0;
        done       = 1'b0;
        halted     = 1'b0;
        cnt_en     = 1'b0;
        ir_d       = ir_q;
        rout_sel_d = rout_sel_q;
`ifdef PROC_CTRL_HALT_EN
        halt_d     = halt_q;
        halted     = halt_q;
`endif
        unique case (step)
            T0: begin
                if (run) begin
                    ir_in  = 1'b1;
                    ir_d   = din;
                    cnt_en = 1'b1;
                end
            end
            T1: begin
                case (opc)
                    OP_MV: begin
                        rout_sel_d = ir_q[RY_HI:RY_LO];
                        rout_en    = 1'b1;
                        rin_en     = 1'b1;
                        done       = 1'b1;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        rin_en  = 1'b1;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_sel_d = ir_q[RX_HI:RX_LO];
                        rout_en    = 1'b1;
                        a_in       = 1'b1;
                        cnt_en     = 1'b1;
                    end
`ifdef PROC_CTRL_HALT_EN
                    OP_HALT: begin
                        done   = 1'b1;
                        halt_d = 1'b1;
                    end
`endif
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                rout_sel_d = ir_q[RY_HI:RY_LO];
                rout_en    = 1'b1;
                g_in       = 1'b1;
                add_sub    = ir_q[OPC_LO];
                cnt_en     = 1'b1;
            end
            T3: begin
                g_out  = 1'b1;
                rin_en = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase

        rin_sel  = ir_q[RX_HI:RX_LO];
        rout_sel = rout_sel_d;

        // Reset silences the whole strobe bundle in the same cycle.
        if (rst) begin
            ir_in    = 1'b0;
            rin_sel  = '0;
            rin_en   = 1'b0;
            rout_sel = '0;
            rout_en  = 1'b0;
            din_out  = 1'b0;
            a_in     = 1'b0;
            g_in     = 1'b0;
            g_out    = 1'b0;
            add_sub  = 1'b0;
            done     = 1'b0;
            halted   = 1'b0;
        end
    end

    assign cnt_clr = rst | done;

    proc_step_counter u_step (
        .clk (clk),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q       <= '0;
            rout_sel_q <= '0;
        end else begin
            ir_q       <= ir_d;
            rout_sel_q <= rout_sel_d;
        end
    end

`ifdef PROC_CTRL_HALT_EN
    always_ff @(posedge clk) begin
        if (rst)
            halt_q <= 1'b0;
        else
            halt_q <= halt_d;
    end
`endif

endmodule

// File: tb/tb_proc_control_fsm.sv
// Randomised self-checking bench for proc_control_fsm against an
// instruction-schedule reference model.
module tb_proc_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic [8:0] din = '0;
    logic       ir_in, rin_en, rout_en, din_out;
    logic       a_in, g_in, g_out, add_sub, done, halted;
    logic [2:0] rin_sel, rout_sel;

`ifdef PROC_CTRL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    proc_control_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .din      (din),
        .ir_in    (ir_in),
        .rin_sel  (rin_sel),
        .rin_en   (rin_en),
        .rout_sel (rout_sel),
        .rout_en  (rout_en),
        .din_out  (din_out),
        .a_in     (a_in),
        .g_in     (g_in),
        .g_out    (g_out),
        .add_sub  (add_sub),
        .done     (done),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {ir_in, rin_sel, rin_en, rout_sel, rout_en, din_out,
                  a_in, g_in, g_out, add_sub, done, halted};

    // Reference model: current instruction and how far through it we are.
    logic [8:0]  m_ir   = '0;
    int          m_k    = 0;
    logic [2:0]  m_last = '0;
    bit          m_halt = 1'b0;
    logic [15:0] exp_v;
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic int len_of(input logic [2:0] op);
        return (op == 3'd2 || op == 3'd3) ? 4 : 2;
    endfunction

    function automatic logic [15:0] model_out();
        logic ii, re, oe, dout, ai, gi, go, as, dn, h;
        logic [2:0] rs, os, op;
        {ii, re, oe, dout, ai, gi, go, as, dn, h} = '0;
        op = m_ir[8:6];
        rs = m_ir[5:3];
        os = m_last;
        if (m_halt) begin
            h = 1'b1;
        end else if (m_k == 0) begin
            ii = run;
        end else begin
            dn = (m_k == len_of(op) - 1);
            if (op == 3'd0) begin
                os = m_ir[2:0]; oe = 1'b1; re = 1'b1;
            end else if (op == 3'd1) begin
                dout = 1'b1; re = 1'b1;
            end else if (op == 3'd2 || op == 3'd3) begin
                if (m_k == 1) begin
                    os = m_ir[5:3]; oe = 1'b1; ai = 1'b1;
                end else if (m_k == 2) begin
                    os = m_ir[2:0]; oe = 1'b1; gi = 1'b1; as = op[0];
                end else begin
                    go = 1'b1; re = 1'b1;
                end
            end
        end
        if (rst) return '0;
        return {ii, rs, re, os, oe, dout, ai, gi, go, as, dn, h};
    endfunction

    task automatic drive(input logic r, input logic ru, input logic [8:0] d);
        @(negedge clk);
        rst = r;
        run = ru;
        din = d;
        #1;
        exp_v = model_out();
    endtask

    task automatic advance();
        logic [2:0] op;
        op = m_ir[8:6];
        if (rst) begin
            m_ir = '0; m_k = 0; m_last = '0; m_halt = 1'b0;
        end else if (m_halt) begin
        end else if (m_k == 0) begin
            if (run) begin
                m_ir = din;
                m_k  = 1;
            end
        end else begin
            if (op == 3'd0 || ((op == 3'd2 || op == 3'd3) && m_k == 2))
                m_last = m_ir[2:0];
            else if ((op == 3'd2 || op == 3'd3) && m_k == 1)
                m_last = m_ir[5:3];
            if (m_k == len_of(op) - 1) begin
                m_k = 0;
                if (HALT_EN && op == 3'd7) m_halt = 1'b1;
            end else begin
                m_k++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            assert ($onehot0({rout_en, din_out, g_out}))
            else $error("bus driver conflict rout_en=%b din_out=%b g_out=%b",
                        rout_en, din_out, g_out);
        end
    end

    task automatic test_reset();
        int dn_seen;
        dn_seen = 0;
        for (int i = 0; i < 7; i++) begin
            drive(i < 2, 1'b0, 9'($urandom));
            n_chk++;
            if (obs !== exp_v)
                $display("FAIL reset cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            else n_pass++;
            if (done) dn_seen++;
            advance();
        end
        n_chk++;
        if (dn_seen !== 0)
            $display("FAIL reset_done obs=%0d exp=0", dn_seen);
        else n_pass++;
    endtask

    task automatic test_mv();
        logic [10:0] s [3];
        s = '{{2'b01, 9'b000_011_101}, {2'b00, 9'h000}, {2'b00, 9'h000}};
        for (int i = 0; i < 3; i++) begin
            drive(s[i][10], s[i][9], s[i][8:0]);
            n_chk++;
            if (obs !== exp_v)
                $display("FAIL mv cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_mvi();
        logic [10:0] s [3];
        s = '{{2'b01, 9'b001_010_000}, {2'b00, 9'h0A5}, {2'b00, 9'h000}};
        for (int i = 0; i < 3; i++) begin
            drive(s[i][10], s[i][9], s[i][8:0]);
            n_chk++;
            if (obs !== exp_v)
                $display("FAIL mvi cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_sub();
        int cycles;
        cycles = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, i == 0, i == 0 ? 9'b011_001_110 : 9'($urandom));
            n_chk++;
            if (obs !== exp_v)
                $display("FAIL sub cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            else n_pass++;
            if (!done) cycles++;
            else begin
                n_chk++;
                if (i !== 3) $display("FAIL sub_latency obs=%0d exp=3", i);
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] s [6];
        s = '{{2'b01, 9'b010_100_010}, {2'b00, 9'h000}, {2'b10, 9'h000},
              {2'b00, 9'h000}, {2'b01, 9'b000_001_010}, {2'b00, 9'h000}};
        for (int i = 0; i < 6; i++) begin
            drive(s[i][10], s[i][9], s[i][8:0]);
            n_chk++;
            if (obs !== exp_v)
                $display("FAIL reset_mid cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_opcode7();
        int dn_cnt;
        dn_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, i == 0 ? 9'b111_000_000 : 9'b000_010_011);
            n_chk++;
            if (obs !== exp_v)
                $display("FAIL opcode7 cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            else n_pass++;
            if (done) dn_cnt++;
            advance();
        end
        n_chk++;
        if (dn_cnt !== (HALT_EN ? 1 : 3))
            $display("FAIL opcode7_done obs=%0d exp=%0d", dn_cnt, HALT_EN ? 1 : 3);
        else n_pass++;
        drive(1'b1, 1'b0, '0);
        n_chk++;
        if (obs !== exp_v)
            $display("FAIL opcode7_rst obs=%h exp=%h", obs, exp_v);
        else n_pass++;
        advance();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(99) < 3, $urandom_range(99) < 75, 9'($urandom));
            n_chk++;
            if (obs !== exp_v)
                $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            else n_pass++;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_mv();
        test_mvi();
        test_sub();
        test_reset_mid();
        test_opcode7();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
